// File: rtl/ff1_delay_meter.sv
`default_nettype none
// ============================================================================
// Module   : ff1_delay_meter
// Purpose  : 1-bit master-slave flip-flop clocked by a divided phase, with a
//            D->Q propagation-delay meter. Define ACTIVITY_EN to enable the
//            windowed Q-activity counter (ACT_CNT / ACT_DONE).
// Revision : 1.0
// ============================================================================
module ff1_delay_meter #(
  parameter int DIV       = 10,
  parameter int CNT_W     = 16,
  parameter int WIN_START = 10,
  parameter int WIN_END   = 90,
  parameter int ACT_W     = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             D,
  output logic             Q,
  output logic             PH,
  output logic [CNT_W-1:0] DELAY,
  output logic             DELAY_VLD,
  output logic [ACT_W-1:0] ACT_CNT,
  output logic             ACT_DONE
);

  localparam int               PW         = $clog2(DIV);
  localparam logic [PW-1:0]    C_CNT_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    C_CNT_HALF = PW'(DIV / 2);
  localparam logic [CNT_W-1:0] C_ABORT    = CNT_W'(2 * DIV);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          ph;

  always_comb begin
    cnt_d = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  assign ph = (cnt_q < C_CNT_HALF);
  assign PH = ph;

  always_ff @(posedge CK) begin
    if (RST) begin
      cnt_q <= C_CNT_LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Master is transparent while the phase is low; slave loads one CK after the rise edge.
  logic m_q, q_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      m_q <= 1'b0;
      q_q <= 1'b0;
    end else begin
      if (!ph) begin
        m_q <= D;
      end
      if (cnt_q == '0) begin
        q_q <= m_q;
      end
    end
  end

  assign Q = q_q;

  logic             d_prev_q, q_prev_q;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             start, stop;

  assign start = D ^ d_prev_q;
  assign stop  = q_q ^ q_prev_q;

  // A start coinciding with the stop edge re-arms the meter immediately.
  always_comb begin
    busy_d  = busy_q;
    dcnt_d  = dcnt_q;
    delay_d = delay_q;
    vld_d   = 1'b0;
    if (busy_q) begin
      if (stop) begin
        delay_d = dcnt_q;
        vld_d   = 1'b1;
        busy_d  = start;
        if (start) begin
          dcnt_d = '0;
        end
      end else if (dcnt_q == C_ABORT) begin
        busy_d = 1'b0;
      end else if (dcnt_q != '1) begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      dcnt_d = '0;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      d_prev_q <= 1'b0;
      q_prev_q <= 1'b0;
      busy_q   <= 1'b0;
      dcnt_q   <= '0;
      delay_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      d_prev_q <= D;
      q_prev_q <= q_q;
      busy_q   <= busy_d;
      dcnt_q   <= dcnt_d;
      delay_q  <= delay_d;
      vld_q    <= vld_d;
    end
  end

  assign DELAY     = delay_q;
  assign DELAY_VLD = vld_q;

`ifdef ACTIVITY_EN
  localparam int EW = $clog2(WIN_END + 2);

  logic [EW-1:0]    eidx_q;
  logic [EW-1:0]    idx;
  logic             in_win;
  logic [ACT_W-1:0] act_q;
  logic             done_q;

  // eidx_q holds the last completed edge index, so idx is the index of the current edge.
  assign idx    = eidx_q + 1'b1;
  assign in_win = (idx >= EW'(WIN_START)) && (idx < EW'(WIN_END));

  always_ff @(posedge CK) begin
    if (RST) begin
      eidx_q <= '0;
      act_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (eidx_q != EW'(WIN_END)) begin
        eidx_q <= idx;
      end
      if (stop && in_win && (act_q != '1)) begin
        act_q <= act_q + 1'b1;
      end
      if (idx == EW'(WIN_END)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign ACT_CNT  = act_q;
  assign ACT_DONE = done_q;
`else
  logic unused_win;

  assign unused_win = (WIN_START < WIN_END);
  assign ACT_CNT    = '0;
  assign ACT_DONE   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff1_delay_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff1_delay_meter
// Purpose  : directed + random bench for ff1_delay_meter against an
//            edge-index reference model (honours ACTIVITY_EN if defined).
// Revision : 1.0
// ============================================================================
module tb_ff1_delay_meter;

  localparam int DIV       = 10;
  localparam int CNT_W     = 16;
  localparam int WIN_START = 10;
  localparam int WIN_END   = 90;
  localparam int ACT_W     = 8;
  localparam int MAXE      = 2048;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int ACT_MAX   = (1 << ACT_W) - 1;

  logic             CK  = 1'b0;
  logic             RST = 1'b1;
  logic             D   = 1'b0;
  logic             Q;
  logic             PH;
  logic [CNT_W-1:0] DELAY;
  logic             DELAY_VLD;
  logic [ACT_W-1:0] ACT_CNT;
  logic             ACT_DONE;

  ff1_delay_meter #(
    .DIV       (DIV),
    .CNT_W     (CNT_W),
    .WIN_START (WIN_START),
    .WIN_END   (WIN_END),
    .ACT_W     (ACT_W)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .D         (D),
    .Q         (Q),
    .PH        (PH),
    .DELAY     (DELAY),
    .DELAY_VLD (DELAY_VLD),
    .ACT_CNT   (ACT_CNT),
    .ACT_DONE  (ACT_DONE)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Reference model in terms of edge indices since reset release.
  int   n;
  logic dpre [0:MAXE];
  logic qa   [0:MAXE];
  bit   busy;
  int   t_start;
  int   e_delay;
  bit   e_vld;
  int   e_act;
  bit   e_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    dpre[0] = 1'b0;
    qa[0]   = 1'b0;
    busy    = 1'b0;
    t_start = 0;
    e_delay = 0;
    e_vld   = 1'b0;
    e_act   = 0;
    e_done  = 1'b0;
  endtask

  task automatic model_edge();
    bit st, sp;
    int dc;
    n++;
    if (n >= MAXE) begin
      $display("FAIL model_range: edge index %0d exceeds %0d", n, MAXE);
      $fatal(1, "edge history overflow");
    end
    dpre[n] = D;
    // Q follows D as sampled on the latest rise edge at least one edge back.
    qa[n] = (n < 2) ? 1'b0 : dpre[((n - 2) / DIV) * DIV + 1];
    st = (dpre[n] != dpre[n-1]);
    sp = (n >= 2) && (qa[n-1] != qa[n-2]);
    e_vld = 1'b0;
    if (busy) begin
      dc = n - 1 - t_start;
      if (dc > CNT_MAX) dc = CNT_MAX;
      if (sp) begin
        e_delay = dc;
        e_vld   = 1'b1;
        if (st) t_start = n;
        else    busy = 1'b0;
      end else if (dc == 2 * DIV) begin
        busy = 1'b0;
      end
    end else if (st) begin
      busy    = 1'b1;
      t_start = n;
    end
    if (sp && n >= WIN_START && n < WIN_END && e_act < ACT_MAX) e_act++;
    if (n >= WIN_END) e_done = 1'b1;
  endtask

  task automatic check_all();
    bit e_ph;
    e_ph = (n >= 1) && (((n - 1) % DIV) < DIV / 2);
    chk("Q",         32'(Q),         32'(qa[n]));
    chk("PH",        32'(PH),        32'(e_ph));
    chk("DELAY",     32'(DELAY),     e_delay);
    chk("DELAY_VLD", 32'(DELAY_VLD), 32'(e_vld));
`ifdef ACTIVITY_EN
    chk("ACT_CNT",   32'(ACT_CNT),   e_act);
    chk("ACT_DONE",  32'(ACT_DONE),  32'(e_done));
`else
    chk("ACT_CNT",   32'(ACT_CNT),   0);
    chk("ACT_DONE",  32'(ACT_DONE),  0);
`endif
  endtask

  task automatic step();
    @(posedge CK);
    #1;
    if (RST) model_reset();
    else     model_edge();
    check_all();
  endtask

  task automatic hold_until(input int e);
    for (int i = 0; i < MAXE && n < e; i++) step();
  endtask

  initial begin
    model_reset();

    // Reset for 3 cycles with D low.
    RST = 1'b1;
    D   = 1'b0;
    repeat (3) step();
    chk("rst_Q",     32'(Q),         0);
    chk("rst_PH",    32'(PH),        0);
    chk("rst_DELAY", 32'(DELAY),     0);
    chk("rst_VLD",   32'(DELAY_VLD), 0);
    chk("rst_ACT",   32'(ACT_CNT),   0);
    RST = 1'b0;

    hold_until(1);
    chk("ph_edge1", 32'(PH), 1);
    hold_until(6);
    chk("ph_edge6", 32'(PH), 0);

    // D rises just before rise edge 21.
    hold_until(20);
    D = 1'b1;
    hold_until(22);
    chk("q_latency", 32'(Q), 1);
    hold_until(23);
    chk("dly_min",     32'(DELAY),     1);
    chk("dly_min_vld", 32'(DELAY_VLD), 1);
    hold_until(24);
    chk("vld_single",  32'(DELAY_VLD), 0);

    // D falls just after rise edge 31.
    hold_until(31);
    D = 1'b0;
    hold_until(43);
    chk("dly_max",     32'(DELAY),     DIV);
    chk("dly_max_vld", 32'(DELAY_VLD), 1);

    // Short pulse inside PH high: never reaches Q, meter aborts.
    hold_until(51);
    D = 1'b1;
    hold_until(54);
    D = 1'b0;
    hold_until(62);
    chk("glitch_Q",     32'(Q),     0);
    chk("glitch_DELAY", 32'(DELAY), DIV);

    // New start after the abort, D rises just after rise edge 81.
    hold_until(81);
    D = 1'b1;
    hold_until(93);
    chk("rearm_dly", 32'(DELAY),     DIV);
    chk("rearm_vld", 32'(DELAY_VLD), 1);

    // Random D activity.
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) D = ~D;
      step();
    end

    // Reset in the middle of a measurement.
    D = ~D;
    repeat (3) step();
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    D   = 1'b0;
    repeat (40) step();

    // Activity window: D toggles every 10 cycles, starting high at release.
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    D   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      hold_until(10 * k);
      D = ~D;
    end
    hold_until(89);
`ifdef ACTIVITY_EN
    chk("act_done_89", 32'(ACT_DONE), 0);
`endif
    hold_until(90);
    D = ~D;
`ifdef ACTIVITY_EN
    chk("act_done_90", 32'(ACT_DONE), 1);
`endif
    hold_until(100);
`ifdef ACTIVITY_EN
    chk("act_cnt_win", 32'(ACT_CNT),  8);
    chk("act_done",    32'(ACT_DONE), 1);
`else
    chk("act_cnt_off", 32'(ACT_CNT),  0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ff1_delay_meter.md
# ff1_delay_meter

Synchronous, single-clock model of a clocked 1-bit master-slave flip-flop with a built-in propagation-delay meter. A divider produces a two-phase sampling clock from `CK`. A master/slave register pair clocked by that phase carries `D` to `Q`. A meter counts the `CK` cycles from each `D` transition to the resulting `Q` transition. The block sits in the flip-flop characterisation path; an optional counter records `Q` activity inside a fixed window.

## Interface
- `DIV`, 10: `CK` cycles per phase period. Must be even and ≥2.
- `CNT_W`, 16: width of the delay counter and `DELAY`.
- `WIN_START`, 10: first edge index of the activity window.
- `WIN_END`, 90: edge index one past the end of the activity window.
- `ACT_W`, 8: width of `ACT_CNT`.

Ports:
- `CK`  in  1  system clock; all state updates on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `D`  in  1  data input.
- `Q`  out  1  flip-flop output.
- `PH`  out  1  generated phase clock level.
- `DELAY`  out  `CNT_W`  last measured `D`→`Q` delay, in `CK` cycles.
- `DELAY_VLD`  out  1  one-cycle pulse when `DELAY` updates.
- `ACT_CNT`  out  `ACT_W`  number of `Q` transitions inside the window.
- `ACT_DONE`  out  1  high once the activity window has closed.

## Operation
Edge index: the first `CK` edge with `RST` low is edge 1.

Phase generator:
- Counter `cnt` runs 0..DIV-1 and wraps; reset value is DIV-1.
- `PH` = (`cnt` < DIV/2), combinational.
- The "rise edge" is the edge where `cnt` goes DIV-1→0. Edge 1 is a rise edge.

Flip-flop:
- Master `m` ← `D` on every edge whose pre-edge `PH` = 0. The rise edge is included.
- Slave `Q` ← `m` on every edge whose pre-edge `cnt` = 0.
- Net effect: `Q` takes the value of `D` sampled at the rise edge, one `CK` later.
- `D` changes during `PH` high that revert before the rise edge never reach `Q`.

Delay meter:
- Registers `d_prev` ← `D` and `q_prev` ← `Q` on every edge.
- start = (`D` ≠ `d_prev`) pre-edge; stop = (`Q` ≠ `q_prev`) pre-edge.
- Idle and start: busy ← 1, `dcnt` ← 0.
- Busy: `dcnt` increments each edge, saturating at all-ones.
- Busy and stop: `DELAY` ← `dcnt`, `DELAY_VLD` ← 1 for one cycle, busy ← 0.
- Start while busy is ignored, except on the stop edge itself, where it re-arms: busy stays 1 and `dcnt` ← 0.
- Stop while idle is ignored.
- Busy and `dcnt` = 2·DIV without a stop: abort. busy ← 0, `DELAY` unchanged, no pulse.
- Resulting `DELAY` range is 1..DIV: 1 = `D` changed just before a rise edge; DIV = `D` changed just after one.

## Timing
- Reset values: `cnt`=DIV-1, `PH`=0, `m`=0, `Q`=0, `d_prev`=0, `q_prev`=0, busy=0, `dcnt`=0, `DELAY`=0, `DELAY_VLD`=0, `ACT_CNT`=0, `ACT_DONE`=0.
- `D`=1 at reset release causes a start at edge 1; this is intended.
- `PH` period is DIV cycles, high for DIV/2.
- `Q` latency: 1 `CK` after the rise edge.
- `DELAY_VLD` asserts 1 `CK` after the `Q` change.
- Reset asserted mid-measurement discards it; no pulse is produced.

## Configuration
- `ACTIVITY_EN` defined: an edge-index counter saturates at `WIN_END`.
  - `ACT_CNT` increments (saturating) on each stop condition whose edge index is in [`WIN_START`, `WIN_END`).
  - `ACT_DONE` ← 1 at edge `WIN_END` and holds until reset.
- `ACTIVITY_EN` undefined: `ACT_CNT` and `ACT_DONE` are tied to 0. Ports remain present.

## Test plan
- Reset: `RST`=1 for 3 cycles, `D`=0 → `Q`=0, `PH`=0, `DELAY`=0, `DELAY_VLD`=0, `ACT_CNT`=0.
- Phase, DIV=10 → `PH` high cycles 1–5 and low 6–10 after release, repeating with period 10.
- `D` 0→1 immediately before a rise edge → `Q`=1 one cycle after that edge; `DELAY`=1 with a single-cycle `DELAY_VLD`.
- `D` 0→1 immediately after a rise edge → `DELAY`=10.
- `D` 0→1→0, high for 3 cycles within `PH` high → `Q` stays 0; no `DELAY_VLD`; meter aborts after 20 edges and then accepts a new start.
- `ACTIVITY_EN` defined, `D` toggled every 10 cycles for 100 cycles, window 10..90 → `ACT_CNT`=8 and `ACT_DONE`=1 from edge 90.
